// File: rtl/ex_pkg.sv
// ex_pkg: ALU operation codes, forwarding selects and multiplier FSM states for the execute stage.
package ex_pkg;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SLTU = 5'd7;
    localparam logic [4:0] OP_LUI  = 5'd8;
    localparam logic [4:0] OP_SLL  = 5'd9;
    localparam logic [4:0] OP_SRL  = 5'd10;
    localparam logic [4:0] OP_SRA  = 5'd11;
    localparam logic [4:0] OP_SLLV = 5'd12;
    localparam logic [4:0] OP_SRLV = 5'd13;
    localparam logic [4:0] OP_SRAV = 5'd14;
    localparam logic [4:0] OP_MFHI = 5'd15;
    localparam logic [4:0] OP_MFLO = 5'd16;
    localparam logic [4:0] OP_MULT = 5'd17;
    localparam logic [4:0] OP_MUL  = 5'd18;
    localparam logic [4:0] OP_MTHI = 5'd19;
    localparam logic [4:0] OP_MTLO = 5'd20;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative signed multiplier, one shift-add step per cycle on magnitudes with sign fix-up at the end.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CW = $clog2(DATA_W);

    mul_state_t          state;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic                sign;
    logic [DATA_W:0]     sum;

    // upper half accumulates, lower half holds the not-yet-consumed multiplier bits
    assign sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, acc[0] ? mcand : {DATA_W{1'b0}}};
    assign busy    = state == S_BUSY;
    assign done    = state == S_DONE;
    assign product = sign ? -acc : acc;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_IDLE;
            count <= '0;
            mcand <= '0;
            acc   <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mcand <= a[DATA_W-1] ? -a : a;
                    acc   <= {{DATA_W{1'b0}}, b[DATA_W-1] ? -b : b};
                    sign  <= a[DATA_W-1] ^ b[DATA_W-1];
                    count <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    acc   <= {sum, acc[DATA_W-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(DATA_W-1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, single-cycle ALU, HI/LO, iterative multiply and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] ReadData1In,
    input  logic [DATA_W-1:0] ReadData2In,
    input  logic [DATA_W-1:0] OffsetIn,
    input  logic [4:0]        RtRegIn,
    input  logic [4:0]        RdRegIn,
    input  logic [4:0]        ALUOpIn,
    input  logic [5:0]        functIn,
    input  logic              regDstIn,
    input  logic              ALUSourceIn,
    input  logic              regWriteIn,
    input  logic              MemToRegIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [DATA_W-1:0] MemFwdData,
    input  logic [DATA_W-1:0] WbFwdData,
    output logic              Stall,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [4:0]        WriteRegOut,
    output logic              ZeroOut,
    output logic              regWriteOut,
    output logic              MemToRegOut,
    output logic              MemReadOut,
    output logic              MemWriteOut
);
    logic [DATA_W-1:0]   a, rt_val, b, result, hi, lo;
    logic [2*DATA_W-1:0] product;
    logic                mul_busy, mul_done, mulop;
    logic                unused;

    function automatic logic [DATA_W-1:0] fwd(input logic [DATA_W-1:0] rf, input logic [1:0] sel);
        return !FWD_EN ? rf : sel == FWD_WB ? WbFwdData : sel == FWD_MEM ? MemFwdData : rf;
    endfunction

    assign a      = fwd(ReadData1In, ForwardA);
    assign rt_val = fwd(ReadData2In, ForwardB);
    assign b      = ALUSourceIn ? OffsetIn : rt_val;
    assign mulop  = ALUOpIn == OP_MULT || ALUOpIn == OP_MUL;
    assign Stall  = mulop && !mul_done;
    assign unused = ^{functIn, mul_busy};

    ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .Reset  (Reset),
        .start  (mulop),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(product)
    );

    always_comb begin
        result = '0;
        case (ALUOpIn)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = DATA_W'($signed(a) < $signed(b));
            OP_SLTU: result = DATA_W'(a < b);
            OP_LUI:  result = b << 16;
            OP_SLL:  result = b << OffsetIn[10:6];
            OP_SRL:  result = b >> OffsetIn[10:6];
            OP_SRA:  result = $signed(b) >>> OffsetIn[10:6];
            OP_SLLV: result = b << a[4:0];
            OP_SRLV: result = b >> a[4:0];
            OP_SRAV: result = $signed(b) >>> a[4:0];
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            OP_MUL:  result = product[DATA_W-1:0];
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done && ALUOpIn == OP_MULT) begin
            hi <= product[2*DATA_W-1:DATA_W];
            lo <= product[DATA_W-1:0];
        end else if (ALUOpIn == OP_MTHI) begin
            hi <= a;
        end else if (ALUOpIn == OP_MTLO) begin
            lo <= a;
        end
    end

    // a stalled multiply leaves a bubble: controls cleared, data fields held
    always_ff @(posedge clk) begin
        if (Reset) begin
            ALUResultOut <= '0;
            WriteDataOut <= '0;
            WriteRegOut  <= '0;
            ZeroOut      <= 1'b0;
            regWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            MemReadOut   <= 1'b0;
            MemWriteOut  <= 1'b0;
        end else if (Stall) begin
            regWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            MemReadOut   <= 1'b0;
            MemWriteOut  <= 1'b0;
        end else begin
            ALUResultOut <= result;
            WriteDataOut <= rt_val;
            WriteRegOut  <= regDstIn ? RdRegIn : RtRegIn;
            ZeroOut      <= result == '0;
            regWriteOut  <= regWriteIn;
            MemToRegOut  <= MemToRegIn;
            MemReadOut   <= MemReadIn;
            MemWriteOut  <= MemWriteIn;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed results for the execute stage.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] ReadData1In, ReadData2In, OffsetIn, MemFwdData, WbFwdData;
    logic [4:0]  RtRegIn, RdRegIn, ALUOpIn;
    logic [5:0]  functIn;
    logic        regDstIn, ALUSourceIn, regWriteIn, MemToRegIn, MemReadIn, MemWriteIn;
    logic [1:0]  ForwardA, ForwardB;
    logic        Stall, ZeroOut, regWriteOut, MemToRegOut, MemReadOut, MemWriteOut;
    logic [31:0] ALUResultOut, WriteDataOut;
    logic [4:0]  WriteRegOut;

    int n_cmp = 0;
    int n_bad = 0;
    int n_stall;

    ex_stage dut (
        .clk(clk), .Reset(Reset),
        .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .OffsetIn(OffsetIn),
        .RtRegIn(RtRegIn), .RdRegIn(RdRegIn), .ALUOpIn(ALUOpIn), .functIn(functIn),
        .regDstIn(regDstIn), .ALUSourceIn(ALUSourceIn), .regWriteIn(regWriteIn),
        .MemToRegIn(MemToRegIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MemFwdData(MemFwdData), .WbFwdData(WbFwdData),
        .Stall(Stall), .ALUResultOut(ALUResultOut), .WriteDataOut(WriteDataOut),
        .WriteRegOut(WriteRegOut), .ZeroOut(ZeroOut), .regWriteOut(regWriteOut),
        .MemToRegOut(MemToRegOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb);
        ALUOpIn     = op;
        ReadData1In = ra;
        ReadData2In = rb;
        OffsetIn    = '0;
        RtRegIn     = 5'd3;
        RdRegIn     = 5'd9;
        functIn     = '0;
        regDstIn    = 1'b1;
        ALUSourceIn = 1'b0;
        regWriteIn  = 1'b1;
        MemToRegIn  = 1'b0;
        MemReadIn   = 1'b0;
        MemWriteIn  = 1'b0;
        ForwardA    = FWD_RF;
        ForwardB    = FWD_RF;
        MemFwdData  = '0;
        WbFwdData   = '0;
    endtask

    // waits out the multiply stall, checking the bubble once along the way
    task automatic wait_mul(input logic [31:0] held);
        n_stall = 0;
        while (Stall === 1'b1 && n_stall < 100) begin
            tick();
            n_stall++;
            if (n_stall == 10) begin
                check("bubble_regwrite", regWriteOut, 0);
                check("bubble_hold", ALUResultOut, held);
            end
        end
        check("stall_cycles", n_stall, 33);
    endtask

    initial begin
        drive(OP_ADD, 0, 0);
        Reset = 1'b1;
        tick();
        tick();
        check("rst_result", ALUResultOut, 0);
        check("rst_ctrl", {regWriteOut, MemToRegOut, MemReadOut, MemWriteOut, ZeroOut}, 0);
        check("rst_stall", Stall, 0);
        Reset = 1'b0;

        drive(OP_ADD, 5, 3);
        ForwardA = 2'b10;
        MemFwdData = 7;
        #1 check("add_stall", Stall, 0);
        tick();
        check("add_fwd", ALUResultOut, 10);
        check("add_fwd_zero", ZeroOut, 0);
        check("add_wreg", WriteRegOut, 9);
        check("add_regw", regWriteOut, 1);
        check("add_wdata", WriteDataOut, 3);

        drive(OP_ADD, 32'hFFFF_FFFF, 1);
        tick();
        check("add_wrap", ALUResultOut, 0);
        check("add_wrap_zero", ZeroOut, 1);

        drive(OP_ADD, 1, 3);
        ForwardA = 2'b11;
        MemFwdData = 7;
        ForwardB = 2'b01;
        WbFwdData = 100;
        tick();
        check("fwd_b_wb", ALUResultOut, 101);
        check("fwd_b_wdata", WriteDataOut, 100);

        drive(OP_SRA, 0, 32'h8000_0000);
        OffsetIn = 32'h0000_0100;
        tick();
        check("sra_shamt", ALUResultOut, 32'hF800_0000);

        drive(OP_SLT, 32'hFFFF_FFFF, 1);
        tick();
        check("slt", ALUResultOut, 1);

        drive(OP_SLTU, 32'hFFFF_FFFF, 1);
        tick();
        check("sltu", ALUResultOut, 0);

        drive(OP_LUI, 0, 0);
        ALUSourceIn = 1'b1;
        OffsetIn = 32'h0000_1234;
        regDstIn = 1'b0;
        tick();
        check("lui", ALUResultOut, 32'h1234_0000);
        check("lui_wreg_rt", WriteRegOut, 3);

        drive(OP_SRLV, 4, 32'h80);
        tick();
        check("srlv", ALUResultOut, 32'h8);

        drive(OP_MTHI, 32'hDEAD_BEEF, 0);
        tick();
        drive(OP_MFHI, 0, 0);
        tick();
        check("mthi_mfhi", ALUResultOut, 32'hDEAD_BEEF);

        drive(OP_ADD, 1, 1);
        Reset = 1'b1;
        tick();
        tick();
        check("midrst_result", ALUResultOut, 0);
        check("midrst_wdata", WriteDataOut, 0);
        check("midrst_wreg", WriteRegOut, 0);
        check("midrst_regw", regWriteOut, 0);
        check("midrst_stall", Stall, 0);
        Reset = 1'b0;
        drive(OP_MFHI, 0, 0);
        tick();
        check("midrst_mfhi", ALUResultOut, 0);

        drive(OP_ADD, 2, 3);
        tick();
        check("pre_mult_add", ALUResultOut, 5);

        drive(OP_MULT, 32'hFFFF_FFFD, 7);
        #1 check("mult_stall_on", Stall, 1);
        wait_mul(5);
        tick();
        check("mult_hi", dut.hi, 32'hFFFF_FFFF);
        check("mult_lo", dut.lo, 32'hFFFF_FFEB);
        drive(OP_MFLO, 0, 0);
        tick();
        check("mult_mflo", ALUResultOut, 32'hFFFF_FFEB);
        drive(OP_MFHI, 0, 0);
        tick();
        check("mult_mfhi", ALUResultOut, 32'hFFFF_FFFF);

        drive(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        #1;
        wait_mul(32'hFFFF_FFFF);
        tick();
        check("mul_result", ALUResultOut, 0);
        check("mul_zero", ZeroOut, 1);
        check("mul_regw", regWriteOut, 1);
        check("mul_hi_kept", dut.hi, 32'hFFFF_FFFF);
        check("mul_lo_kept", dut.lo, 32'hFFFF_FFEB);

        drive(OP_MULT, 5, 5);
        repeat (11) tick();
        check("abort_busy", dut.u_mul.busy, 1);
        Reset = 1'b1;
        drive(OP_ADD, 0, 0);
        tick();
        Reset = 1'b0;
        #1;
        check("abort_stall", Stall, 0);
        check("abort_idle", dut.u_mul.busy | dut.u_mul.done, 0);
        check("abort_hi", dut.hi, 0);
        check("abort_lo", dut.lo, 0);

        drive(OP_MULT, 6, 7);
        #1;
        wait_mul(0);
        tick();
        check("remult_lo", dut.lo, 42);
        check("remult_hi", dut.hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
